// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, sequencer states
// and writeback-control width.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int WB_CTRL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_be.sv
// Single-port data RAM, 32-bit words with per-byte write strobes.
// Writes are synchronous; reads are combinational so the MEM stage can capture on commit.
module dmem_be #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: lane alignment, load extension, multi-cycle access sequencer
// and the MEM/WB register.
//
// state | meaning
// IDLE  | accepting a new EX/MEM slot; single-cycle ops and LAT=1 accesses complete here
// BUSY  | multi-cycle access in flight; commits when count reaches LAT-1
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          write_data,
    input  logic [4:0]           write_reg,
    input  logic [WB_CTRL_W-1:0] wb_control,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic                 branch,
    input  logic                 zero,
    output logic                 pcsrc,
    output logic                 stall,
    output logic                 wb_valid,
    output logic [31:0]          wb_read_data,
    output logic [31:0]          wb_alu_result,
    output logic [4:0]           wb_write_reg,
    output logic [WB_CTRL_W-1:0] wb_control_out,
    output logic                 wb_misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);

    state_e          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            mem_op, misalign, go_mem, commit, stall_int;
    logic [3:0]      be, we;
    logic [31:0]     lane_wdata, rdata, load_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            unused_addr;

    logic                 v_nxt, mis_nxt;
    logic [31:0]          rd_nxt, alu_nxt;
    logic [4:0]           reg_nxt;
    logic [WB_CTRL_W-1:0] ctl_nxt;

    assign pcsrc = in_valid & branch & zero;

    assign mem_op   = mem_read | mem_write;
    assign misalign = mem_op & (((mem_size == MEM_HALF) & alu_result[0]) |
                                (mem_size[1] & (|alu_result[1:0])));
    assign go_mem   = in_valid & mem_op & ~misalign;
    assign commit   = go_mem & (((LAT == 1) && (state == IDLE)) ||
                                ((state == BUSY) && (count == LAST)));

    always_comb begin
        stall_int = 1'b0;
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (go_mem && (LAT > 1)) begin
                    stall_int = 1'b1;
                    state_nxt = BUSY;
                    count_nxt = CW'(1);
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else begin
                    stall_int = 1'b1;
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Reset must drop stall immediately, even while the upstream slot is still presented.
    assign stall = stall_int & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        case (mem_size)
            MEM_BYTE: begin
                be         = 4'b0001 << alu_result[1:0];
                lane_wdata = {4{write_data[7:0]}};
            end
            MEM_HALF: begin
                be         = alu_result[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{write_data[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = write_data;
            end
        endcase
    end

    assign we = (commit && mem_write && rst_n) ? be : 4'b0000;

    dmem_be #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (alu_result[AW+1:2]),
        .wdata (lane_wdata),
        .rdata (rdata)
    );

    assign unused_addr = ^{alu_result[31:AW+2]};

    assign ld_byte = rdata[{alu_result[1:0], 3'b000} +: 8];
    assign ld_half = rdata[{alu_result[1], 4'b0000} +: 16];

    always_comb begin
        case (mem_size)
            MEM_BYTE: load_data = mem_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            MEM_HALF: load_data = mem_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:  load_data = rdata;
        endcase
    end

    always_comb begin
        v_nxt   = 1'b0;
        mis_nxt = 1'b0;
        rd_nxt  = '0;
        alu_nxt = '0;
        reg_nxt = '0;
        ctl_nxt = '0;
        if (commit) begin
            v_nxt   = 1'b1;
            rd_nxt  = mem_write ? 32'h0 : load_data;
            alu_nxt = alu_result;
            reg_nxt = write_reg;
            ctl_nxt = wb_control;
        end else if (in_valid && !stall_int && (state == IDLE)) begin
            // Misaligned accesses retire with writeback suppressed.
            v_nxt   = 1'b1;
            alu_nxt = alu_result;
            reg_nxt = write_reg;
            if (misalign) begin
                mis_nxt = 1'b1;
            end else begin
                ctl_nxt = wb_control;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            wb_read_data   <= '0;
            wb_alu_result  <= '0;
            wb_write_reg   <= '0;
            wb_control_out <= '0;
            wb_misalign    <= 1'b0;
        end else begin
            wb_valid       <= v_nxt;
            wb_read_data   <= rd_nxt;
            wb_alu_result  <= alu_nxt;
            wb_write_reg   <= reg_nxt;
            wb_control_out <= ctl_nxt;
            wb_misalign    <= mis_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: a LAT=1 and a LAT=4 instance share one
// stimulus bus, selected by sel; a monitor pops expected MEM/WB rows on wb_valid.
module tb_mem_stage_pipe;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n1, rst_n4, sel;
    logic        in_valid, mem_read, mem_write, mem_unsigned, branch, zero;
    logic [31:0] alu_result, write_data;
    logic [4:0]  write_reg;
    logic [1:0]  wb_control, mem_size;

    logic        pcsrc_1, stall_1, valid_1, mis_1;
    logic        pcsrc_4, stall_4, valid_4, mis_4;
    logic [31:0] rd_1, alu_1, rd_4, alu_4;
    logic [4:0]  wreg_1, wreg_4;
    logic [1:0]  ctl_1, ctl_4;

    logic        m_pcsrc, m_stall, m_valid, m_mis;
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_wreg;
    logic [1:0]  m_ctl;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [1:0]  ctl;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DEPTH(256), .LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n1), .in_valid(in_valid & ~sel),
        .alu_result(alu_result), .write_data(write_data), .write_reg(write_reg),
        .wb_control(wb_control), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .branch(branch), .zero(zero),
        .pcsrc(pcsrc_1), .stall(stall_1), .wb_valid(valid_1), .wb_read_data(rd_1),
        .wb_alu_result(alu_1), .wb_write_reg(wreg_1), .wb_control_out(ctl_1),
        .wb_misalign(mis_1)
    );

    mem_stage_pipe #(.DEPTH(256), .LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(in_valid & sel),
        .alu_result(alu_result), .write_data(write_data), .write_reg(write_reg),
        .wb_control(wb_control), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .branch(branch), .zero(zero),
        .pcsrc(pcsrc_4), .stall(stall_4), .wb_valid(valid_4), .wb_read_data(rd_4),
        .wb_alu_result(alu_4), .wb_write_reg(wreg_4), .wb_control_out(ctl_4),
        .wb_misalign(mis_4)
    );

    assign m_pcsrc = sel ? pcsrc_4 : pcsrc_1;
    assign m_stall = sel ? stall_4 : stall_1;
    assign m_valid = sel ? valid_4 : valid_1;
    assign m_mis   = sel ? mis_4   : mis_1;
    assign m_rd    = sel ? rd_4    : rd_1;
    assign m_alu   = sel ? alu_4   : alu_1;
    assign m_wreg  = sel ? wreg_4  : wreg_1;
    assign m_ctl   = sel ? ctl_4   : ctl_1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_wb: wb_valid=1 with no pending entry, alu=%h (t=%0t)", m_alu, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wb_read_data",   m_rd,          e.rd);
                check("wb_alu_result",  m_alu,         e.alu);
                check("wb_write_reg",   32'(m_wreg),   32'(e.wreg));
                check("wb_control_out", 32'(m_ctl),    32'(e.ctl));
                check("wb_misalign",    32'(m_mis),    32'(e.mis));
            end
        end
    end

    task automatic issue(input logic s, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wr_reg, input logic [1:0] ctl, input int exp_stall,
                         input logic [31:0] exp_rd, input logic exp_mis, input logic probe);
        exp_t e;
        int   n;
        @(negedge clk);
        sel = s; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        alu_result = addr; write_data = wd; write_reg = wr_reg; wb_control = ctl;
        branch = 1'b0; zero = 1'b0; in_valid = 1'b1;
        e.rd = exp_rd; e.alu = addr; e.wreg = wr_reg; e.ctl = exp_mis ? 2'b00 : ctl; e.mis = exp_mis;
        q.push_back(e);
        #1;
        n = 0;
        while (m_stall === 1'b1 && n < 16) begin
            n++;
            if (n >= 2) check("bubble_valid", 32'(m_valid), 32'd0);
            if (probe && n == 2) begin
                branch = 1'b1; zero = 1'b1;
                #1 check("pcsrc_taken", 32'(m_pcsrc), 32'd1);
                zero = 1'b0;
                #1 check("pcsrc_not_taken", 32'(m_pcsrc), 32'd0);
                branch = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = SZ_W;
        mem_unsigned = 1'b0; branch = 1'b0; zero = 1'b0; alu_result = '0; write_data = '0;
        write_reg = '0; wb_control = '0;
        rst_n1 = 1'b1; rst_n4 = 1'b1;
        #1 rst_n1 = 1'b0; rst_n4 = 1'b0;
        sel = 1'b1; in_valid = 1'b1; mem_read = 1'b1; alu_result = 32'h10;
        #1;
        check("rst_stall_lat4",   32'(stall_4), 32'd0);
        check("rst_valid_lat4",   32'(valid_4), 32'd0);
        check("rst_valid_lat1",   32'(valid_1), 32'd0);
        check("rst_alu_lat1",     alu_1,        32'd0);
        check("rst_rd_lat4",      rd_4,         32'd0);
        check("rst_ctl_mis_lat1", 32'({ctl_1, mis_1, wreg_1}), 32'd0);
        in_valid = 1'b0; mem_read = 1'b0; sel = 1'b0;
        idle(2);
        rst_n1 = 1'b1; rst_n4 = 1'b1;
        idle(1);

        //     s  rd wr size  uns addr       wdata        reg  ctl  stl exp_rd        mis pr
        issue(0, 0, 1, SZ_W, 0, 32'h004, 32'h12345678, 5'd0, 2'b10, 0, 32'h0,        0, 0);
        issue(0, 1, 0, SZ_W, 1, 32'h004, 32'h0,        5'd5, 2'b11, 0, 32'h12345678, 0, 0);
        issue(0, 0, 1, SZ_B, 0, 32'h005, 32'hAAAAAA80, 5'd0, 2'b00, 0, 32'h0,        0, 0);
        issue(0, 1, 0, SZ_B, 0, 32'h005, 32'h0,        5'd6, 2'b11, 0, 32'hFFFFFF80, 0, 0);
        issue(0, 1, 0, SZ_B, 1, 32'h005, 32'h0,        5'd6, 2'b11, 0, 32'h00000080, 0, 0);
        issue(0, 1, 0, SZ_W, 0, 32'h004, 32'h0,        5'd8, 2'b01, 0, 32'h12348078, 0, 0);
        issue(0, 1, 0, SZ_H, 0, 32'h006, 32'h0,        5'd9, 2'b11, 0, 32'h00001234, 0, 0);
        issue(0, 1, 0, SZ_H, 0, 32'h004, 32'h0,        5'd9, 2'b11, 0, 32'hFFFF8078, 0, 0);
        issue(0, 1, 0, SZ_H, 1, 32'h004, 32'h0,        5'd9, 2'b11, 0, 32'h00008078, 0, 0);
        issue(0, 1, 0, SZ_B, 1, 32'h007, 32'h0,        5'd3, 2'b11, 0, 32'h00000012, 0, 0);
        issue(0, 0, 1, SZ_W, 0, 32'h008, 32'h00000000, 5'd0, 2'b00, 0, 32'h0,        0, 0);
        issue(0, 0, 1, SZ_H, 0, 32'h00A, 32'hCAFEBEEF, 5'd0, 2'b00, 0, 32'h0,        0, 0);
        issue(0, 1, 0, SZ_W, 0, 32'h008, 32'h0,        5'd4, 2'b11, 0, 32'hBEEF0000, 0, 0);
        issue(0, 1, 0, SZ_H, 0, 32'h003, 32'h0,        5'd2, 2'b11, 0, 32'h0,        1, 0);
        issue(0, 0, 1, SZ_W, 0, 32'h006, 32'hFFFFFFFF, 5'd0, 2'b11, 0, 32'h0,        1, 0);
        issue(0, 1, 0, SZ_W, 0, 32'h004, 32'h0,        5'd5, 2'b11, 0, 32'h12348078, 0, 0);
        issue(0, 0, 0, SZ_W, 0, 32'hDEADBEEF, 32'h0,   5'd7, 2'b01, 0, 32'h0,        0, 0);
        issue(0, 1, 1, SZ_W, 0, 32'h00C, 32'h5555AAAA, 5'd1, 2'b11, 0, 32'h0,        0, 0);
        issue(0, 1, 0, 2'b11, 0, 32'h00C, 32'h0,       5'd1, 2'b11, 0, 32'h5555AAAA, 0, 0);
        issue(0, 1, 0, SZ_W, 0, 32'h404, 32'h0,        5'd1, 2'b11, 0, 32'h12348078, 0, 0);
        idle(2);
        check("idle_valid", 32'(m_valid), 32'd0);
        check("idle_ctl",   32'(m_ctl),   32'd0);
        check("idle_alu",   m_alu,        32'd0);

        issue(1, 0, 1, SZ_W, 0, 32'h010, 32'h11223344, 5'd0, 2'b10, 3, 32'h0,        0, 0);
        issue(1, 1, 0, SZ_W, 0, 32'h010, 32'h0,        5'd9, 2'b11, 3, 32'h11223344, 0, 1);
        issue(1, 1, 0, SZ_H, 0, 32'h003, 32'h0,        5'd2, 2'b11, 0, 32'h0,        1, 0);
        issue(1, 1, 0, SZ_B, 1, 32'h011, 32'h0,        5'd3, 2'b11, 3, 32'h00000033, 0, 0);

        @(negedge clk);
        sel = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = SZ_W; alu_result = 32'h010;
        write_data = 32'hDEADDEAD; write_reg = 5'd0; wb_control = 2'b00; in_valid = 1'b1;
        #1 check("abort_stall_1", 32'(m_stall), 32'd1);
        @(negedge clk);
        #1 check("abort_stall_2", 32'(m_stall), 32'd1);
        rst_n4 = 1'b0;
        #1;
        check("abort_stall_low", 32'(m_stall), 32'd0);
        check("abort_wb_valid",  32'(m_valid), 32'd0);
        check("abort_wb_fields", m_alu | m_rd | 32'({m_ctl, m_mis, m_wreg}), 32'd0);
        in_valid = 1'b0;
        idle(2);
        rst_n4 = 1'b1;
        idle(1);

        issue(1, 1, 0, SZ_W, 0, 32'h010, 32'h0,        5'd6, 2'b11, 3, 32'h11223344, 0, 0);
        issue(1, 0, 0, SZ_W, 0, 32'h00ABCDEF, 32'h0,   5'd7, 2'b01, 0, 32'h0,        0, 0);

        idle(3);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
